// File: rtl/smoldvi_pattern_gen.sv
// Test-pattern pixel source for a ready-throttled DVI sink: gradient, colour bars, checkerboard, solid.
// Optional build macro SMOLDVI_PATTERN_BORDER_EN forces a one-pixel white frame border in every mode.
module smoldvi_pattern_gen #(
   parameter int H_ACTIVE   = 640,
   parameter int V_ACTIVE   = 480,
   parameter int X_STEP     = 2,
   parameter int CHECK_LOG2 = 4
) (
   input  logic        clk_pix,
   input  logic        rst_pix,
   input  logic        rgb_rdy,
   input  logic [1:0]  mode,
   input  logic        freeze,
   input  logic [23:0] solid_rgb,
   output logic [7:0]  r,
   output logic [7:0]  g,
   output logic [7:0]  b,
   output logic        sof,
   output logic [7:0]  frame_ctr
);

   localparam int XW = $clog2(H_ACTIVE);
   localparam int YW = $clog2(V_ACTIVE);
   localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - X_STEP);
   localparam logic [XW-1:0] X_INC  = XW'(X_STEP);
   localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);
   localparam logic [YW-1:0] Y_ONE  = YW'(1);

   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;
   logic [7:0]    frame_q, frame_d;
   logic [1:0]    mode_q, mode_d;
   logic [7:0]    r_q, r_d, g_q, g_d, b_q, b_d;
   logic          sof_q, sof_d;

   logic          x_wrap, y_wrap;
   logic [6:0]    bar_ge;
   logic [2:0]    bar_idx;
   logic          chk_bit;
   logic [23:0]   pix_rgb;

   always_comb begin
      x_wrap  = (x_q >= X_LAST);
      y_wrap  = (y_q == Y_LAST);
      x_d     = x_q;
      y_d     = y_q;
      frame_d = frame_q;
      mode_d  = mode_q;
      if (rgb_rdy) begin
         x_d = x_wrap ? '0 : x_q + X_INC;
         if (x_wrap) begin
            y_d = y_wrap ? '0 : y_q + Y_ONE;
            if (y_wrap) begin
               frame_d = freeze ? frame_q : frame_q + 8'd1;
               mode_d  = mode;
            end
         end
      end
   end

   // Bar k starts at ceil(k*H_ACTIVE/8); the bar index is how many of those thresholds x has passed.
   generate
      for (genvar gi = 0; gi < 7; gi++) begin : g_bar_th
         localparam int TH = ((gi + 1) * H_ACTIVE + 7) / 8;
         assign bar_ge[gi] = (x_d >= XW'(TH));
      end
   endgenerate

   always_comb begin
      bar_idx = 3'd0;
      for (int k = 0; k < 7; k++) begin
         bar_idx = bar_idx + {2'b00, bar_ge[k]};
      end
   end

   generate
      if (CHECK_LOG2 < XW && CHECK_LOG2 < YW) begin : g_chk_xy
         assign chk_bit = x_d[CHECK_LOG2] ^ y_d[CHECK_LOG2];
      end else if (CHECK_LOG2 < XW) begin : g_chk_x
         assign chk_bit = x_d[CHECK_LOG2];
      end else if (CHECK_LOG2 < YW) begin : g_chk_y
         assign chk_bit = y_d[CHECK_LOG2];
      end else begin : g_chk_none
         assign chk_bit = 1'b0;
      end
   endgenerate

   // Colour is derived from next-state counters so it lands in the same register stage as them.
   always_comb begin
      case (mode_d)
         2'd0:    pix_rgb = {8'(x_d) + frame_d, 8'(y_d) + {frame_d[6:0], 1'b0}, frame_d};
         2'd1:    pix_rgb = {{8{~bar_idx[2]}}, {8{~bar_idx[1]}}, {8{~bar_idx[0]}}};
         2'd2:    pix_rgb = {24{chk_bit}};
         default: pix_rgb = solid_rgb;
      endcase
`ifdef SMOLDVI_PATTERN_BORDER_EN
      if (x_d == '0 || x_d >= X_LAST || y_d == '0 || y_d == Y_LAST) begin
         pix_rgb = 24'hFFFFFF;
      end
`endif
      r_d   = rgb_rdy ? pix_rgb[23:16] : r_q;
      g_d   = rgb_rdy ? pix_rgb[15:8]  : g_q;
      b_d   = rgb_rdy ? pix_rgb[7:0]   : b_q;
      sof_d = rgb_rdy ? (x_d == '0 && y_d == '0) : sof_q;
   end

   always_ff @(posedge clk_pix) begin
      if (rst_pix) begin
         x_q     <= '0;
         y_q     <= '0;
         frame_q <= 8'd0;
         mode_q  <= 2'd0;
         r_q     <= 8'd0;
         g_q     <= 8'd0;
         b_q     <= 8'd0;
         sof_q   <= 1'b1;
      end else begin
         x_q     <= x_d;
         y_q     <= y_d;
         frame_q <= frame_d;
         mode_q  <= mode_d;
         r_q     <= r_d;
         g_q     <= g_d;
         b_q     <= b_d;
         sof_q   <= sof_d;
      end
   end

   assign r         = r_q;
   assign g         = g_q;
   assign b         = b_q;
   assign sof       = sof_q;
   assign frame_ctr = frame_q;

endmodule

// File: tb/tb_smoldvi_pattern_gen.sv
// Directed bench for smoldvi_pattern_gen on a shrunken 16x4 raster (8 accepts per line, 32 per frame).
module tb_smoldvi_pattern_gen;

   localparam int H  = 16;
   localparam int V  = 4;
   localparam int XS = 2;
   localparam int CL = 1;

   logic        clk_pix = 1'b0;
   logic        rst_pix;
   logic        rgb_rdy;
   logic [1:0]  mode;
   logic        freeze;
   logic [23:0] solid_rgb;
   logic [7:0]  r, g, b;
   logic        sof;
   logic [7:0]  frame_ctr;

   int tests_run    = 0;
   int tests_failed = 0;

   // Reference state: pixel position, frame, latched mode and the colour expected on the outputs.
   int          mx, my, mf, mmode;
   logic [23:0] ergb;
   logic        esof;

   smoldvi_pattern_gen #(
      .H_ACTIVE(H), .V_ACTIVE(V), .X_STEP(XS), .CHECK_LOG2(CL)
   ) dut (
      .clk_pix(clk_pix), .rst_pix(rst_pix), .rgb_rdy(rgb_rdy), .mode(mode),
      .freeze(freeze), .solid_rgb(solid_rgb), .r(r), .g(g), .b(b),
      .sof(sof), .frame_ctr(frame_ctr)
   );

   always #5 clk_pix = ~clk_pix;

   function automatic logic [23:0] ref_rgb(input int x, input int y, input int f, input int m);
      logic [23:0] c;
      int bar;
      case (m)
         0: c = {8'(x + f), 8'(y + 2 * f), 8'(f)};
         1: begin
            bar = (x * 8) / H;
            c = {((bar & 4) != 0) ? 8'h00 : 8'hFF,
                 ((bar & 2) != 0) ? 8'h00 : 8'hFF,
                 ((bar & 1) != 0) ? 8'h00 : 8'hFF};
         end
         2: c = (((x ^ y) >> CL) & 1) != 0 ? 24'hFFFFFF : 24'h000000;
         default: c = solid_rgb;
      endcase
`ifdef SMOLDVI_PATTERN_BORDER_EN
      if (x == 0 || x >= H - XS || y == 0 || y == V - 1) c = 24'hFFFFFF;
`endif
      return c;
   endfunction

   function automatic logic [32:0] exp_bus();
      return {ergb, esof, 8'(mf)};
   endfunction

   function automatic logic [32:0] dut_bus();
      return {r, g, b, sof, frame_ctr};
   endfunction

   // One clock with the given ready; the model advances exactly as the sink saw it at the edge.
   task automatic step(input logic rdy);
      rgb_rdy = rdy;
      @(posedge clk_pix);
      #1;
      if (rst_pix) begin
         mx = 0; my = 0; mf = 0; mmode = 0;
         ergb = 24'h0; esof = 1'b1;
      end else if (rdy) begin
         if (mx >= H - XS) begin
            mx = 0;
            if (my == V - 1) begin
               my = 0;
               if (!freeze) mf = (mf + 1) % 256;
               mmode = mode;
            end else begin
               my = my + 1;
            end
         end else begin
            mx = mx + XS;
         end
         ergb = ref_rgb(mx, my, mf, mmode);
         esof = (mx == 0 && my == 0);
      end
   endtask

   task automatic run_to(input int tx, input int ty);
      for (int n = 0; n < 200 && !(mx == tx && my == ty); n++) step(1'b1);
   endtask

   task automatic test_reset();
      rst_pix = 1'b1; mode = 2'd3; solid_rgb = 24'h123456; freeze = 1'b0;
      step(1'b1);
      step(1'b1);
      tests_run++;
      if ({r, g, b, sof, frame_ctr} !== {24'h000000, 1'b1, 8'd0}) begin
         tests_failed++;
         $display("FAIL reset_state: got %h expected %h", dut_bus(), {24'h000000, 1'b1, 8'd0});
      end
      rst_pix = 1'b0; mode = 2'd0;
   endtask

   task automatic test_gradient();
      for (int i = 0; i < 32; i++) begin
         step(1'b1);
         tests_run++;
         if (dut_bus() !== exp_bus()) begin
            tests_failed++;
            $display("FAIL gradient[%0d]: got %h expected %h", i, dut_bus(), exp_bus());
         end
      end
      // 32 accepts from (0,0) of frame 0 lands on (0,0) of frame 1.
      tests_run++;
      if ({frame_ctr, sof} !== {8'd1, 1'b1}) begin
         tests_failed++;
         $display("FAIL frame_wrap: got fc=%0d sof=%b expected fc=1 sof=1", frame_ctr, sof);
      end
`ifndef SMOLDVI_PATTERN_BORDER_EN
      tests_run++;
      if ({r, g, b} !== 24'h010201) begin
         tests_failed++;
         $display("FAIL gradient_f1: got %h expected 010201", {r, g, b});
      end
`endif
   endtask

   task automatic test_stall();
      logic [32:0] prev;
      logic rdy;
      for (int i = 0; i < 100; i++) begin
         rdy = ($urandom_range(0, 99) < 30);
         prev = dut_bus();
         step(rdy);
         tests_run++;
         if (!rdy && dut_bus() !== prev) begin
            tests_failed++;
            $display("FAIL stall_hold[%0d]: got %h expected %h", i, dut_bus(), prev);
         end else if (dut_bus() !== exp_bus()) begin
            tests_failed++;
            $display("FAIL stall_seq[%0d]: got %h expected %h", i, dut_bus(), exp_bus());
         end
      end
   endtask

   task automatic test_mode_switch();
      run_to(0, 2);
      mode = 2'd1;
      for (int n = 0; n < 64 && !(mx == 0 && my == 0); n++) begin
         step(1'b1);
         tests_run++;
         if (dut_bus() !== exp_bus()) begin
            tests_failed++;
            $display("FAIL mode_hold[%0d]: got %h expected %h", n, dut_bus(), exp_bus());
         end
      end
      tests_run++;
      if ({r, g, b} !== 24'hFFFFFF) begin
         tests_failed++;
         $display("FAIL bar0: got %h expected ffffff", {r, g, b});
      end
      for (int i = 1; i < 8; i++) begin
         step(1'b1);
         tests_run++;
         if (dut_bus() !== exp_bus()) begin
            tests_failed++;
            $display("FAIL bars[%0d]: got %h expected %h", i, dut_bus(), exp_bus());
         end
`ifndef SMOLDVI_PATTERN_BORDER_EN
         if (i == 4) begin
            tests_run++;
            if ({r, g, b} !== 24'h00FFFF) begin
               tests_failed++;
               $display("FAIL bar4: got %h expected 00ffff", {r, g, b});
            end
         end
`endif
      end
      tests_run++;
      if ({r, g, b} !== 24'h000000 && !(`ifdef SMOLDVI_PATTERN_BORDER_EN 1 `else 0 `endif)) begin
         tests_failed++;
         $display("FAIL bar7: got %h expected 000000", {r, g, b});
      end
   endtask

   task automatic test_checker();
      mode = 2'd2;
      run_to(0, 0);
      step(1'b1);
      run_to(0, 0);
      for (int i = 0; i < 32; i++) begin
         step(1'b1);
         tests_run++;
         if (dut_bus() !== exp_bus()) begin
            tests_failed++;
            $display("FAIL checker[%0d]: got %h expected %h", i, dut_bus(), exp_bus());
         end
         if (mx == 2 && my == 0) begin
            tests_run++;
            if ({r, g, b} !== 24'hFFFFFF) begin
               tests_failed++;
               $display("FAIL checker_2_0: got %h expected ffffff", {r, g, b});
            end
         end
         if (mx == 4 && my == 1) begin
            tests_run++;
            if ({r, g, b} !== 24'h000000) begin
               tests_failed++;
               $display("FAIL checker_4_1: got %h expected 000000", {r, g, b});
            end
         end
      end
   endtask

   task automatic test_freeze();
      logic [7:0] hold;
      hold = frame_ctr;
      freeze = 1'b1; mode = 2'd3; solid_rgb = 24'h123456;
      for (int i = 0; i < 80; i++) begin
         step(1'b1);
         tests_run++;
         if (dut_bus() !== exp_bus() || frame_ctr !== 8'(mf)) begin
            tests_failed++;
            $display("FAIL freeze[%0d]: got %h expected %h", i, dut_bus(), exp_bus());
         end
         if (mmode == 3 && mx == 4 && my == 1) begin
            tests_run++;
            if ({r, g, b} !== 24'h123456) begin
               tests_failed++;
               $display("FAIL solid: got %h expected 123456", {r, g, b});
            end
         end
      end
      tests_run++;
      if (frame_ctr !== hold || mf != int'(hold)) begin
         tests_failed++;
         $display("FAIL freeze_hold: got %0d expected %0d", frame_ctr, hold);
      end
      freeze = 1'b0;
   endtask

   task automatic test_reset_midframe();
      mode = 2'd0;
      run_to(6, 2);
      rst_pix = 1'b1;
      step(1'b0);
      rst_pix = 1'b0;
      tests_run++;
      if ({r, g, b, sof, frame_ctr} !== {24'h000000, 1'b1, 8'd0}) begin
         tests_failed++;
         $display("FAIL reset_mid: got %h expected %h", dut_bus(), {24'h000000, 1'b1, 8'd0});
      end
      step(1'b1);
      tests_run++;
      if (dut_bus() !== exp_bus() || sof !== 1'b0) begin
         tests_failed++;
         $display("FAIL restart: got %h expected %h", dut_bus(), exp_bus());
      end
`ifndef SMOLDVI_PATTERN_BORDER_EN
      tests_run++;
      if ({r, g, b} !== 24'h020000) begin
         tests_failed++;
         $display("FAIL restart_px: got %h expected 020000", {r, g, b});
      end
`endif
   endtask

   initial begin
      rst_pix = 1'b1; rgb_rdy = 1'b0; mode = 2'd0; freeze = 1'b0; solid_rgb = 24'h0;
      mx = 0; my = 0; mf = 0; mmode = 0; ergb = 24'h0; esof = 1'b1;
      test_reset();
      test_gradient();
      test_stall();
      test_mode_switch();
      test_checker();
      test_freeze();
      test_reset_midframe();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/smoldvi_pattern_gen.md
SMOLDVI_PATTERN_GEN -- requirements
Module: smoldvi_pattern_gen

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- H_ACTIVE, 640, active pixels per line at clk_pix rate.
- V_ACTIVE, 480, active lines per frame.
- X_STEP, 2, x increment per accepted pixel (pixel-repeat factor).
- CHECK_LOG2, 4, log2 of checkerboard square size in pixels.
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
- clk_pix  input  1  pixel clock; the only clock.
- rst_pix  input  1  synchronous, active-high reset.
- rgb_rdy  input  1  sink accepted the current pixel this cycle.
- mode  input  2  pattern select: 0 gradient, 1 colour bars, 2 checkerboard, 3 solid.
- freeze  input  1  hold frame_ctr at frame wrap.
- solid_rgb  input  24  {r,g,b} for mode 3.
- r, g, b  output  8 each  registered current pixel colour.
- sof  output  1  high while the current pixel is (0,0).
- frame_ctr  output  8  frame count.

Function
REQ-003 x_ctr SHALL be $clog2(H_ACTIVE) bits wide and y_ctr SHALL be $clog2(V_ACTIVE) bits wide.
REQ-004 The counters, frame_ctr and mode_q SHALL change only on cycles where rgb_rdy=1.
REQ-005 r/g/b/sof SHALL be held stable on cycles where rgb_rdy=0.
REQ-006 On an accept, if x_ctr >= H_ACTIVE-X_STEP then x_ctr SHALL go to 0; otherwise x_ctr SHALL go to x_ctr+X_STEP.
REQ-007 On x wrap, if y_ctr == V_ACTIVE-1 then y_ctr SHALL go to 0; otherwise y_ctr SHALL go to y_ctr+1.
REQ-008 On frame wrap (x and y wrap together), frame_ctr SHALL increment modulo 256 unless freeze=1, in which case it SHALL hold.
REQ-009 On frame wrap, mode_q SHALL load mode; mode changes mid-frame SHALL NOT affect the current frame.
REQ-010 Colour SHALL be computed from the next-state (x, y, frame, mode_q) and registered on the same edge, so outputs always match the counters with zero added latency.
REQ-011 Gradient (mode 0): r = x+frame, g = y+2*frame, b = frame, each truncated to 8 bits.
REQ-012 Colour bars (mode 1): bar index i = floor(x*8/H_ACTIVE), implemented as 7 constant comparator thresholds with no runtime multiply or divide; r = {8{~i[2]}}, g = {8{~i[1]}}, b = {8{~i[0]}}, so bar 0 is white and bar 7 is black.
REQ-013 Checkerboard (mode 2): when bit CHECK_LOG2 of (x XOR y) is 1, output SHALL be FF,FF,FF; otherwise 00,00,00.
REQ-014 Solid (mode 3): r = solid_rgb[23:16], g = solid_rgb[15:8], b = solid_rgb[7:0], sampled combinationally into the output register on each accept.
REQ-015 sof SHALL be registered and asserted exactly when next-state x = 0 and y = 0.

Reset
REQ-016 While rst_pix=1 at a clk_pix edge: x_ctr=0, y_ctr=0, frame_ctr=0, mode_q=0, r=g=b=00, sof=1, irrespective of rgb_rdy.
REQ-017 Reset asserted mid-frame SHALL restart at pixel (0,0) of frame 0 on the first cycle after deassertion.

Configuration
REQ-018 With macro SMOLDVI_PATTERN_BORDER_EN defined, any pixel with x=0, x >= H_ACTIVE-X_STEP, y=0 or y=V_ACTIVE-1 SHALL output FF,FF,FF in all modes, overriding REQ-011 to REQ-014.
REQ-019 With SMOLDVI_PATTERN_BORDER_EN undefined, no border logic SHALL be present and colours SHALL follow REQ-011 to REQ-014 only.

Verification
REQ-020 Reset, then rgb_rdy=1 continuously in mode 0 -> x steps 0,2,...,638,0; y increments on each x wrap; after 320*480 accepts frame_ctr=1 and sof=1.
REQ-021 rgb_rdy toggling pseudo-randomly at 30% duty -> the accepted pixel sequence is identical to REQ-020, and outputs never change on rgb_rdy=0 cycles.
REQ-022 mode changed from 0 to 1 at y=100 -> the current frame remains gradient; the next frame shows 8 bars of 80 pixels each, FFFFFF first and 000000 at x>=560.
REQ-023 freeze=1 across two frame wraps -> frame_ctr holds; mode 3 with solid_rgb=123456 -> r=12, g=34, b=56 on every pixel.
REQ-024 rst_pix pulsed for 1 cycle at (x=300, y=200) -> next cycle x=0, y=0, frame_ctr=0, r=g=b=00, sof=1.
REQ-025 Built with SMOLDVI_PATTERN_BORDER_EN in mode 2 -> row 0, row 479, x=0 and x=638 are FFFFFF; interior follows the 16-pixel checkerboard; built without the macro -> interior pattern extends to the edges.
